adc_serial_responder: RTL and testbench

Synthesizable responder (slave) for the serial ADC link driven by the ADC controller. It emulates the external ADC chip so the host-to-SDRAM readout path can run in hardware loopback and in simulation without the analog front end. It oversamples the controller's SCLK, CS and DIN on the 100 MHz system clock, captures 16-bit command frames, and shifts 16-bit sample words out on DOUT. Sample words come from an internal ramp generator or from an external sample port.

---
 rtl/adc_responder_pkg.sv | 19 +
 rtl/adc_responder_sync.sv | 32 +++
 rtl/adc_serial_responder.sv | 191 +++++++++++++++++++
 tb/tb_adc_serial_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the serial ADC responder and its controller bench.
package adc_responder_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} respState_t;

  localparam int FRAME_BITS_DEF = 16;

  // Command opcode field within a 16-bit command word.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  // Slot of each asynchronous pin in the synchronizer array.
  localparam int SRC_SCLK = 0;
  localparam int SRC_CS   = 1;
  localparam int SRC_DIN  = 2;
  localparam int SRC_RST  = 3;
  localparam int NUM_SRC  = 4;

endpackage

// File: rtl/adc_responder_sync.sv
// Multi-flop synchronizer followed by a registered rise/fall detector.
// level, rise and fall are mutually aligned, SYNC_STAGES+1 cycles after the pin.
module adc_responder_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] syncQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= {SYNC_STAGES{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      syncQ[0] <= async;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
      level <= syncQ[SYNC_STAGES-1];
      rise  <= syncQ[SYNC_STAGES-1] & ~level;
      fall  <= ~syncQ[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC chip emulator: captures 16-bit commands on DIN, shifts ramp or external samples on DOUT.
// Optional SCLK rate check enabled by defining ADC_RESPONDER_FRQ_CHECK_EN.
module adc_serial_responder import adc_responder_pkg::*; #(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 1
`ifdef ADC_RESPONDER_FRQ_CHECK_EN
  , parameter int MIN_SCLK_PERIOD = 50
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_sclk,
  input  logic        adc_cs,
  input  logic        adc_din,
  input  logic        adc_rst,
  output logic        adc_dout,
  input  logic        use_external,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ack,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  output logic        frame_error,
  output logic        underrun,
  output logic        busy
`ifdef ADC_RESPONDER_FRQ_CHECK_EN
  , output logic      sclk_too_fast
`endif
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  // CS and adc_rst idle high, so their synchronizers come out of reset high.
  localparam logic [NUM_SRC-1:0] SYNC_RST = 4'b1010;

  logic [NUM_SRC-1:0] pinV, lvlV, riseV, fallV;
  assign pinV = {adc_rst, adc_din, adc_cs, adc_sclk};

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSync
    adc_responder_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (SYNC_RST[g])
    ) uSync (
      .clk   (clk),
      .rst_n (rst_n),
      .async (pinV[g]),
      .level (lvlV[g]),
      .rise  (riseV[g]),
      .fall  (fallV[g])
    );
  end

  logic sclkRise, sclkFall, csRise, csFall, dinLvl, clr;
  assign sclkRise = riseV[SRC_SCLK];
  assign sclkFall = fallV[SRC_SCLK];
  assign csRise   = riseV[SRC_CS];
  assign csFall   = fallV[SRC_CS];
  assign dinLvl   = lvlV[SRC_DIN];
  assign clr      = ~lvlV[SRC_RST];

  logic unusedEdges;
  assign unusedEdges = ^{riseV[SRC_DIN], fallV[SRC_DIN], riseV[SRC_RST], fallV[SRC_RST],
                         lvlV[SRC_SCLK], lvlV[SRC_CS]};

  respState_t        state, stateNxt;
  logic [CNT_W-1:0]  bitCnt;
  logic [15:0]       doutShift, dinShift, ramp, loadWord;
  logic              startPend;

  // A CS fall seen during DONE is remembered so the next frame is not lost.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (csFall || startPend) stateNxt = LOAD;
      LOAD:    stateNxt = csRise ? DONE : SHIFT;
      SHIFT:   if (csRise) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    loadWord = ramp;
    if (use_external) loadWord = sample_valid ? sample_data : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_dout    <= 1'b0;
      doutShift   <= '0;
      dinShift    <= '0;
      bitCnt      <= '0;
      ramp        <= '0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      sample_ack  <= 1'b0;
      underrun    <= 1'b0;
      startPend   <= 1'b0;
    end else if (clr) begin
      adc_dout    <= 1'b0;
      doutShift   <= '0;
      dinShift    <= '0;
      bitCnt      <= '0;
      ramp        <= '0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      sample_ack  <= 1'b0;
      underrun    <= 1'b0;
      startPend   <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      sample_ack  <= 1'b0;
      underrun    <= 1'b0;
      if (state == DONE && csFall) startPend <= 1'b1;
      else if (state == IDLE)      startPend <= 1'b0;
      case (state)
        LOAD: begin
          bitCnt    <= '0;
          doutShift <= loadWord;
          adc_dout  <= loadWord[15];
          sample_ack <= use_external & sample_valid;
          underrun   <= use_external & ~sample_valid;
        end
        SHIFT: begin
          if (sclkRise) begin
            dinShift <= {dinShift[14:0], dinLvl};
            if (bitCnt != CNT_W'(FRAME_BITS + 1)) bitCnt <= bitCnt + 1'b1;
          end
          // Once all bits have gone out DOUT parks on the LSB.
          if (sclkFall && bitCnt < CNT_W'(FRAME_BITS)) begin
            doutShift <= {doutShift[14:0], 1'b0};
            adc_dout  <= doutShift[14];
          end
        end
        DONE: begin
          if (bitCnt == CNT_W'(FRAME_BITS)) begin
            cmd_data  <= dinShift;
            cmd_valid <= 1'b1;
            ramp      <= ramp + 16'(RAMP_STEP);
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef ADC_RESPONDER_FRQ_CHECK_EN
  logic [15:0] periodCnt;
  logic        haveRise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodCnt     <= '0;
      haveRise      <= 1'b0;
      sclk_too_fast <= 1'b0;
    end else if (clr) begin
      periodCnt     <= '0;
      haveRise      <= 1'b0;
      sclk_too_fast <= 1'b0;
    end else begin
      sclk_too_fast <= 1'b0;
      if (csFall) begin
        periodCnt <= '0;
        haveRise  <= 1'b0;
      end else if (state == SHIFT && sclkRise) begin
        periodCnt <= '0;
        haveRise  <= 1'b1;
        // periodCnt+1 is the number of clk cycles since the previous rise.
        if (haveRise && ({1'b0, periodCnt} + 17'd1) < 17'(MIN_SCLK_PERIOD))
          sclk_too_fast <= 1'b1;
      end else if (periodCnt != 16'hFFFF) begin
        periodCnt <= periodCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder acting as the ADC controller, with dout/cmd scoreboards.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        rst_n, adc_sclk, adc_cs, adc_din, adc_rst, adc_dout;
  logic        use_external, sample_valid, sample_ack, cmd_valid, frame_error, underrun, busy;
  logic [15:0] sample_data, cmd_data;
`ifdef ADC_RESPONDER_FRQ_CHECK_EN
  logic        sclk_too_fast;
`endif

  adc_serial_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_sclk     (adc_sclk),
    .adc_cs       (adc_cs),
    .adc_din      (adc_din),
    .adc_rst      (adc_rst),
    .adc_dout     (adc_dout),
    .use_external (use_external),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ack   (sample_ack),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .frame_error  (frame_error),
    .underrun     (underrun),
    .busy         (busy)
`ifdef ADC_RESPONDER_FRQ_CHECK_EN
    , .sclk_too_fast (sclk_too_fast)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cmdValidCnt = 0, frameErrCnt = 0, ackCnt = 0, underrunCnt = 0, fastCnt = 0, runLen = 0;
  logic [15:0] doutQ[$];
  logic [15:0] cmdQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse counters and the command scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_ack)  ackCnt++;
      if (underrun)    underrunCnt++;
      if (frame_error) frameErrCnt++;
`ifdef ADC_RESPONDER_FRQ_CHECK_EN
      if (sclk_too_fast) fastCnt++;
`endif
      if (cmd_valid) begin
        cmdValidCnt++;
        runLen++;
        if (runLen == 1) begin
          if (cmdQ.size() != 0) check("cmd_data", {16'h0, cmd_data}, {16'h0, cmdQ.pop_front()});
          else                  check("cmd_spurious", {31'h0, cmd_valid}, 32'h0);
        end
      end else begin
        if (runLen != 0) check("cmd_valid_width", runLen, 1);
        runLen = 0;
      end
    end
  end

  // Drives one CS-low frame of nbits SCLK periods and captures DOUT ahead of each rise.
  task automatic frame(input logic [15:0] cmd, input int nbits, input bit expWord,
                       input logic [15:0] expDout, input int half);
    logic [15:0] got = '0;
    if (expWord) doutQ.push_back(expDout);
    if (nbits == 16) cmdQ.push_back(cmd);
    @(negedge clk) adc_cs = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_in_frame", {31'h0, busy}, 32'h1);
    for (int i = 0; i < nbits; i++) begin
      adc_din = cmd[15-i];
      repeat (half) @(negedge clk);
      got = {got[14:0], adc_dout};
      adc_sclk = 1'b1;
      repeat (half) @(negedge clk);
      adc_sclk = 1'b0;
    end
    repeat (20) @(negedge clk);
    adc_cs = 1'b1;
    if (expWord) check("dout_word", {16'h0, got}, {16'h0, doutQ.pop_front()});
    repeat (40) @(negedge clk);
  endtask

  int cv, fe, ak, ur;

  initial begin
    rst_n = 1'b0; adc_sclk = 1'b0; adc_cs = 1'b1; adc_din = 1'b0; adc_rst = 1'b1;
    use_external = 1'b0; sample_data = 16'h0; sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dout",   {31'h0, adc_dout},    32'h0);
    check("rst_cmd",    {16'h0, cmd_data},    32'h0);
    check("rst_cmdv",   {31'h0, cmd_valid},   32'h0);
    check("rst_busy",   {31'h0, busy},        32'h0);
    check("rst_ferr",   {31'h0, frame_error}, 32'h0);
    check("rst_undr",   {31'h0, underrun},    32'h0);
    check("rst_ack",    {31'h0, sample_ack},  32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Ramp mode, three frames.
    frame(16'h1234, 16, 1, 16'h0000, 100);
    frame(16'hA5C3, 16, 1, 16'h0001, 100);
    check("cmd_a5c3", {16'h0, cmd_data}, 32'hA5C3);
    frame(16'h0F0F, 16, 1, 16'h0002, 100);
    check("cmd_valid_cnt3", cmdValidCnt, 3);
    check("no_frame_err", frameErrCnt, 0);
    check("busy_idle", {31'h0, busy}, 32'h0);

    // External mode: valid sample, then underrun.
    use_external = 1'b1; sample_data = 16'hBEEF; sample_valid = 1'b1;
    frame(16'h5A5A, 16, 1, 16'hBEEF, 100);
    check("ack_once", ackCnt, 1);
    check("no_underrun", underrunCnt, 0);
    sample_valid = 1'b0;
    frame(16'h0001, 16, 1, 16'h0000, 100);
    check("underrun_once", underrunCnt, 1);
    check("ack_still1", ackCnt, 1);
    use_external = 1'b0;

    // Short frame: 9 rises, expect frame_error and nothing else changing.
    cv = cmdValidCnt;
    frame(16'hFFFF, 9, 0, 16'h0000, 100);
    check("frame_err", frameErrCnt, 1);
    check("short_cmd_kept", {16'h0, cmd_data}, 32'h0001);
    check("short_no_cmdv", cmdValidCnt, cv);
    frame(16'h7777, 16, 1, 16'h0005, 100);

    // Ramp wrap.
    @(negedge clk) force dut.ramp = 16'hFFFF;
    @(negedge clk) release dut.ramp;
    frame(16'h1111, 16, 1, 16'hFFFF, 100);
    frame(16'h2222, 16, 1, 16'h0000, 100);

    // adc_rst mid-frame at bit 7 with an all-ones external word.
    use_external = 1'b1; sample_data = 16'hFFFF; sample_valid = 1'b1;
    cv = cmdValidCnt; fe = frameErrCnt; ak = ackCnt; ur = underrunCnt;
    @(negedge clk) adc_cs = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      adc_din = 1'b1;
      repeat (100) @(negedge clk);
      adc_sclk = 1'b1;
      repeat (100) @(negedge clk);
      adc_sclk = 1'b0;
    end
    repeat (10) @(negedge clk);
    check("pre_rst_dout", {31'h0, adc_dout}, 32'h1);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    adc_rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_dout", {31'h0, adc_dout}, 32'h0);
    check("rst_mid_cmd", {16'h0, cmd_data}, 32'h0);
    adc_cs = 1'b1;
    repeat (20) @(negedge clk);
    adc_rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_cmdv", cmdValidCnt, cv);
    check("rst_mid_no_ferr", frameErrCnt, fe);
    check("rst_mid_ack", ackCnt, ak + 1);
    check("rst_mid_no_undr", underrunCnt, ur);
    use_external = 1'b0;
    frame(16'h3333, 16, 1, 16'h0000, 100);
    check("no_fast_slow_sclk", fastCnt, 0);

`ifdef ADC_RESPONDER_FRQ_CHECK_EN
    frame(16'h4444, 16, 1, 16'h0001, 10);
    check("sclk_too_fast_seen", {31'h0, fastCnt > 0}, 32'h1);
`endif

    check("dout_q_drained", doutQ.size(), 0);
    check("cmd_q_drained", cmdQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
